// File: rtl/score_keeper_pkg.sv
// rtl/score_keeper_pkg.sv - shared constants and state type for the score keeper
// Contents: asteroid point values (BCD), default lives settings, FSM state enum.
package score_keeper_pkg;

    localparam logic [8:0] PTS_LARGE = 9'h020;
    localparam logic [8:0] PTS_MED   = 9'h050;
    localparam logic [8:0] PTS_SMALL = 9'h100;

    localparam int LIVES_INIT_DEF = 3;
    localparam int LIVES_MAX_DEF  = 9;

    typedef enum logic [1:0] {SK_IDLE, SK_PLAY, SK_OVER} score_state_t;

endpackage

// File: rtl/score_keeper_if.sv
// rtl/score_keeper_if.sv - game-event inputs and score/lives outputs of the score keeper
// master: game logic side (drives new_game, ship_hit, ast_points; reads status).
// slave:  score keeper side (reads events; drives score, high_score, lives, playing,
//         game_over, extra_life).
interface score_keeper_if #(
    parameter int NUM_SRC = 2,
    parameter int DIGITS  = 6
);
    logic                      new_game;
    logic                      ship_hit;
    logic [NUM_SRC-1:0][8:0]   ast_points;
    logic [DIGITS*4-1:0]       score;
    logic [DIGITS*4-1:0]       high_score;
    logic [3:0]                lives;
    logic                      playing;
    logic                      game_over;
    logic                      extra_life;

    modport master (
        output new_game, ship_hit, ast_points,
        input  score, high_score, lives, playing, game_over, extra_life
    );

    modport slave (
        input  new_game, ship_hit, ast_points,
        output score, high_score, lives, playing, game_over, extra_life
    );
endinterface

// File: rtl/score_keeper_bcd_digit_add.sv
// rtl/score_keeper_bcd_digit_add.sv - one-digit BCD adder with carry
// Ports: a, b (BCD digits), cin -> sum (BCD digit), cout.
module bcd_digit_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] raw;

    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        cout = (raw > 5'd9);
        // +6 skips the six unused codes and wraps back into 0..9
        sum  = cout ? 4'(raw + 5'd6) : raw[3:0];
    end
endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - BCD score, lives, high score and game-over sequencing
// Ports: clk, resetN (async active-low), bus (score_keeper_if.slave):
//   new_game/ship_hit pulses, ast_points[NUM_SRC] BCD points in;
//   score/high_score (BCD), lives, playing, game_over, extra_life out.
// Points are captured per source into 3-digit pending accumulators, then one
// nonzero accumulator per cycle is drained round-robin into a single score adder.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int NUM_SRC     = 2,
    parameter int DIGITS      = 6,
    parameter int LIVES_INIT  = LIVES_INIT_DEF,
    parameter int LIVES_MAX   = LIVES_MAX_DEF,
    parameter int EXTRA_DIGIT = 4
) (
    input  logic                 clk,
    input  logic                 resetN,
    score_keeper_if.slave        bus
);
    localparam int SW  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int SCW = DIGITS * 4;

    score_state_t                state;
    logic [NUM_SRC-1:0][11:0]    pend;
    logic [NUM_SRC-1:0][11:0]    pend_nxt;
    logic [SW-1:0]               ptr;
    logic [SW-1:0]               cand;
    logic [SW-1:0]               sel_idx;
    logic                        sel_valid;
    logic [11:0]                 drain_val;
    logic [SCW-1:0]              score_q;
    logic [SCW-1:0]              high_q;
    logic [SCW-1:0]              sum_raw;
    logic [SCW-1:0]              score_sum;
    logic [DIGITS:0]             scy;
    logic [3:0]                  lives_q;
    logic                        playing_q;
    logic                        over_q;
    logic                        extra_q;
    logic                        grant;

    // Round-robin pick: first nonzero accumulator at or after ptr.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = SW'((int'(ptr) + k) % NUM_SRC);
            if (!sel_valid && pend[cand] != 12'h000) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign drain_val = sel_valid ? pend[sel_idx] : 12'h000;

    // Capture adders: a source drained this cycle restarts from zero so that
    // simultaneous drain and capture never loses the new points.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [11:0] base;
        logic [11:0] pts;
        logic [11:0] raw;
        logic [3:0]  cy;

        assign base  = (sel_valid && sel_idx == SW'(i)) ? 12'h000 : pend[i];
        assign pts   = {3'b000, bus.ast_points[i]};
        assign cy[0] = 1'b0;

        for (genvar d = 0; d < 3; d++) begin : g_dig
            bcd_digit_add u_add (
                .a    (base[d*4 +: 4]),
                .b    (pts[d*4 +: 4]),
                .cin  (cy[d]),
                .sum  (raw[d*4 +: 4]),
                .cout (cy[d+1])
            );
        end

        assign pend_nxt[i] = cy[3] ? 12'h999 : raw;
    end

    // Score ripple adder with the drained accumulator zero-extended.
    assign scy[0] = 1'b0;
    for (genvar d = 0; d < DIGITS; d++) begin : g_score
        logic [3:0] b_dig;
        assign b_dig = (d < 3) ? drain_val[(d % 3)*4 +: 4] : 4'h0;
        bcd_digit_add u_add (
            .a    (score_q[d*4 +: 4]),
            .b    (b_dig),
            .cin  (scy[d]),
            .sum  (sum_raw[d*4 +: 4]),
            .cout (scy[d+1])
        );
    end

    assign score_sum = scy[DIGITS] ? {DIGITS{4'h9}} : sum_raw;

    // Judged on the saturated result, so clamping to all-9s without the upper
    // digits moving grants nothing.
    assign grant = (state == SK_PLAY) && sel_valid &&
                   (score_sum[SCW-1:EXTRA_DIGIT*4] != score_q[SCW-1:EXTRA_DIGIT*4]);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= SK_IDLE;
            score_q   <= '0;
            high_q    <= '0;
            lives_q   <= '0;
            playing_q <= 1'b0;
            over_q    <= 1'b0;
            extra_q   <= 1'b0;
            pend      <= '0;
            ptr       <= '0;
        end else begin
            extra_q <= 1'b0;
            if (bus.new_game) begin
                state     <= SK_PLAY;
                playing_q <= 1'b1;
                over_q    <= 1'b0;
                score_q   <= '0;
                lives_q   <= 4'(LIVES_INIT);
                pend      <= '0;
                ptr       <= '0;
            end else if (state == SK_PLAY) begin
                score_q <= score_sum;
                pend    <= pend_nxt;
                extra_q <= grant;
                if (sel_valid) begin
                    ptr <= (sel_idx == SW'(NUM_SRC - 1)) ? '0 : sel_idx + SW'(1);
                end
                if (bus.ship_hit && !grant) begin
                    lives_q <= lives_q - 4'd1;
                    if (lives_q == 4'd1) begin
                        state     <= SK_OVER;
                        playing_q <= 1'b0;
                        over_q    <= 1'b1;
                        pend      <= '0;
                        // Packed BCD orders the same as binary, MSD first.
                        if (score_sum > high_q) begin
                            high_q <= score_sum;
                        end
                    end
                end else if (grant && !bus.ship_hit && lives_q < 4'(LIVES_MAX)) begin
                    lives_q <= lives_q + 4'd1;
                end
            end
        end
    end

    assign bus.score      = score_q;
    assign bus.high_score = high_q;
    assign bus.lives      = lives_q;
    assign bus.playing    = playing_q;
    assign bus.game_over  = over_q;
    assign bus.extra_life = extra_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - self-checking bench for score_keeper
module tb_score_keeper;
    import score_keeper_pkg::*;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    score_keeper_if #(.NUM_SRC(2), .DIGITS(6)) bus ();

    score_keeper #(
        .NUM_SRC(2), .DIGITS(6), .LIVES_INIT(3), .LIVES_MAX(9), .EXTRA_DIGIT(4)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    int checks    = 0;
    int failures  = 0;
    int ext_cnt   = 0;
    int ext0      = 0;
    int exp_total = 0;
    logic [23:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetN && bus.extra_life) ext_cnt++;
    end

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int t;
        t = v;
        r = '0;
        for (int d = 0; d < 6; d++) begin
            r[d*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int pts_val(input logic [8:0] p);
        return int'(p[8]) * 100 + int'(p[7:4]) * 10 + int'(p[3:0]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [8:0] p0, input logic [8:0] p1);
        bus.ast_points[0] = p0;
        bus.ast_points[1] = p1;
        exp_total += pts_val(p0) + pts_val(p1);
        if (exp_total > 999999) exp_total = 999999;
        tick();
        bus.ast_points = '0;
    endtask

    task automatic start_game();
        bus.new_game = 1'b1;
        tick();
        bus.new_game = 1'b0;
        exp_total = 0;
    endtask

    task automatic hit();
        bus.ship_hit = 1'b1;
        tick();
        bus.ship_hit = 1'b0;
    endtask

    task automatic push_exp();
        exp_q.push_back(to_bcd(exp_total));
    endtask

    task automatic wait_settle(input string tag);
        logic [23:0] last;
        int stable;
        int n;
        last   = bus.score;
        stable = 0;
        n      = 0;
        while (stable < 3 && n < 200) begin
            tick();
            n++;
            if (bus.score == last) stable++;
            else begin
                stable = 0;
                last   = bus.score;
            end
        end
        if (stable < 3) check_eq({tag, "_timeout"}, 32'(stable), 32'd3);
        check_eq(tag, 32'(bus.score), 32'(exp_q.pop_front()));
    endtask

    task automatic build_9980();
        repeat (49) drive(PTS_SMALL, PTS_SMALL);
        drive(PTS_SMALL, PTS_LARGE);
        drive(PTS_LARGE, PTS_LARGE);
        drive(PTS_LARGE, 9'h000);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_score"},   32'(bus.score), 32'd0);
        check_eq({tag, "_high"},    32'(bus.high_score), 32'd0);
        check_eq({tag, "_lives"},   32'(bus.lives), 32'd0);
        check_eq({tag, "_playing"}, 32'(bus.playing), 32'd0);
        check_eq({tag, "_over"},    32'(bus.game_over), 32'd0);
        check_eq({tag, "_extra"},   32'(bus.extra_life), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.new_game   = 1'b0;
        bus.ship_hit   = 1'b0;
        bus.ast_points = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        resetN = 1'b1;
        tick();

        // First capture/drain latency
        start_game();
        check_eq("ng_lives", 32'(bus.lives), 32'd3);
        check_eq("ng_playing", 32'(bus.playing), 32'd1);
        check_eq("ng_over", 32'(bus.game_over), 32'd0);
        bus.ast_points[0] = PTS_LARGE;
        exp_total += 20;
        tick();
        bus.ast_points = '0;
        check_eq("lat_n1", 32'(bus.score), 32'h0);
        tick();
        check_eq("lat_n2", 32'(bus.score), 32'h20);
        push_exp();
        wait_settle("lat_settle");

        // Two sources in the same cycle
        start_game();
        drive(PTS_SMALL, PTS_MED);
        tick();
        tick();
        check_eq("two_src", 32'(bus.score), 32'h150);
        push_exp();
        wait_settle("two_src_settle");

        // Extra life at 10000
        start_game();
        ext0 = ext_cnt;
        build_9980();
        push_exp();
        wait_settle("s9980");
        check_eq("s9980_lives", 32'(bus.lives), 32'd3);
        check_eq("s9980_ext", 32'(ext_cnt - ext0), 32'd0);
        drive(PTS_LARGE, 9'h000);
        push_exp();
        wait_settle("s10000");
        check_eq("s10000_ext", 32'(ext_cnt - ext0), 32'd1);
        check_eq("s10000_lives", 32'(bus.lives), 32'd4);

        // Climb to 999950: 98 further boundaries, lives clamp at 9
        ext0 = ext_cnt;
        repeat (4949) drive(PTS_SMALL, PTS_SMALL);
        drive(PTS_SMALL, PTS_MED);
        push_exp();
        wait_settle("s999950");
        check_eq("s999950_ext", 32'(ext_cnt - ext0), 32'd98);
        check_eq("s999950_lives", 32'(bus.lives), 32'd9);

        // Saturation, no grant
        ext0 = ext_cnt;
        drive(PTS_SMALL, 9'h000);
        push_exp();
        wait_settle("sat");
        check_eq("sat_ext", 32'(ext_cnt - ext0), 32'd0);
        check_eq("sat_lives", 32'(bus.lives), 32'd9);

        // Lose all lives
        repeat (8) hit();
        check_eq("hit8_lives", 32'(bus.lives), 32'd1);
        check_eq("hit8_playing", 32'(bus.playing), 32'd1);
        hit();
        check_eq("over_flag", 32'(bus.game_over), 32'd1);
        check_eq("over_playing", 32'(bus.playing), 32'd0);
        check_eq("over_high", 32'(bus.high_score), 32'h999999);
        check_eq("over_lives", 32'(bus.lives), 32'd0);

        // Inputs ignored in OVER
        bus.ast_points[0] = PTS_SMALL;
        bus.ship_hit = 1'b1;
        tick();
        bus.ast_points = '0;
        bus.ship_hit = 1'b0;
        tick();
        tick();
        check_eq("ign_score", 32'(bus.score), 32'h999999);
        check_eq("ign_lives", 32'(bus.lives), 32'd0);
        check_eq("ign_over", 32'(bus.game_over), 32'd1);

        // New game keeps the high score
        start_game();
        check_eq("ng2_score", 32'(bus.score), 32'h0);
        check_eq("ng2_lives", 32'(bus.lives), 32'd3);
        check_eq("ng2_high", 32'(bus.high_score), 32'h999999);
        check_eq("ng2_playing", 32'(bus.playing), 32'd1);
        check_eq("ng2_over", 32'(bus.game_over), 32'd0);

        // Ship hit coinciding with an extra-life grant at lives=1
        hit();
        hit();
        check_eq("ng2_lives1", 32'(bus.lives), 32'd1);
        build_9980();
        push_exp();
        wait_settle("s9980b");
        bus.ast_points[0] = PTS_LARGE;
        exp_total += 20;
        tick();
        bus.ast_points = '0;
        bus.ship_hit = 1'b1;
        tick();
        bus.ship_hit = 1'b0;
        check_eq("gh_lives", 32'(bus.lives), 32'd1);
        check_eq("gh_playing", 32'(bus.playing), 32'd1);
        check_eq("gh_extra", 32'(bus.extra_life), 32'd1);
        check_eq("gh_score", 32'(bus.score), 32'(to_bcd(exp_total)));
        hit();
        check_eq("gh_over", 32'(bus.game_over), 32'd1);
        check_eq("gh_high_kept", 32'(bus.high_score), 32'h999999);

        // Asynchronous reset mid-game
        start_game();
        drive(PTS_SMALL, PTS_SMALL);
        drive(PTS_SMALL, PTS_SMALL);
        #2;
        resetN = 1'b0;
        #1;
        check_all_zero("async_rst");
        tick();
        resetN = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
